// File: rtl/pulse_meter_pkg.sv
// ---------------------------------------------------------------------------
// pulse_meter_pkg
// Shared definitions for the pulse period meter.
//   meter_state_t          : IDLE (waiting for first edge), MEASURE (counting
//                            between edges), TIMEOUT (signal lost)
//   CLK_FREQ_HZ            : nominal system clock (100 MHz)
//   ONE_SECOND_CYCLES      : clk cycles in one second
//   DEFAULT_TIMEOUT_CYCLES : loss-of-signal limit, two seconds of clk
// ---------------------------------------------------------------------------
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } meter_state_t;

    localparam int CLK_FREQ_HZ            = 100_000_000;
    localparam int ONE_SECOND_CYCLES      = CLK_FREQ_HZ;
    localparam int DEFAULT_TIMEOUT_CYCLES = 2 * ONE_SECOND_CYCLES;

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous pulse into the clk domain through a SYNC_STAGES-deep
// flop chain and produces a single-cycle strobe on each rising edge of the
// synchronized signal, however long the pulse stays high.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous active-high reset, clears the whole chain
//   pulse_in    in  asynchronous pulse
//   edge_strobe out one-cycle rising-edge strobe (combinational from flops)
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic edge_strobe
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;

    // Bit 0 takes the raw input; the MSB is the synchronized copy. sync_prev
    // delays the MSB by one cycle so a rising edge is seen exactly once.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_strobe = sync_q[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/pulse_period_meter.sv
// ---------------------------------------------------------------------------
// pulse_period_meter
// Measures the number of clk cycles between successive accepted rising edges
// of pulse_in. Edges that arrive sooner than MIN_PERIOD after the last
// accepted edge are treated as glitches. If no edge is accepted for
// TIMEOUT_CYCLES the meter enters TIMEOUT and the next edge re-arms it.
// Each period is offered through a one-entry valid/ready buffer.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   pulse_in     in   pulse to measure, asynchronous, any high width
//   period_data  out  measured period in clk cycles
//   period_valid out  period_data holds an unconsumed measurement
//   period_ready in   consumer accepts when valid && ready
//   timeout      out  high while in TIMEOUT
//   overrun      out  sticky: a measurement was dropped, buffer full
// ---------------------------------------------------------------------------
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int COUNT_W        = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_PERIOD     = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pulse_in,
    output logic [COUNT_W-1:0] period_data,
    output logic               period_valid,
    input  logic               period_ready,
    output logic               timeout,
    output logic               overrun
);

    localparam logic [63:0]        TIMEOUT_W64 = 64'(TIMEOUT_CYCLES);
    localparam logic [COUNT_W-1:0] MIN_P       = COUNT_W'(MIN_PERIOD);
    localparam logic [COUNT_W-1:0] LAST_CNT    = COUNT_W'(TIMEOUT_CYCLES - 1);

    // Parameter sanity: the counter must be able to hold the longest period
    // that can ever be reported, which is TIMEOUT_CYCLES itself.
    if ((TIMEOUT_W64 >> COUNT_W) != 64'd0) begin : g_bad_count_w
        $error("pulse_period_meter: COUNT_W too narrow for TIMEOUT_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pulse_period_meter: SYNC_STAGES must be >= 2");
    end
    if (MIN_PERIOD < 2) begin : g_bad_min
        $error("pulse_period_meter: MIN_PERIOD must be >= 2");
    end

    meter_state_t       state;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_next;
    logic               edge_strobe;
    logic               emit;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .edge_strobe (edge_strobe)
    );

    // cnt never exceeds TIMEOUT_CYCLES-1, so cnt+1 cannot wrap.
    assign cnt_next = cnt + COUNT_W'(1);

    // An edge while measuring is a real measurement only once at least
    // MIN_PERIOD cycles have elapsed since the previous accepted edge.
    assign emit = (state == MEASURE) && edge_strobe && (cnt_next >= MIN_P);

    // Meter FSM and period counter. The first edge (from IDLE or TIMEOUT)
    // only starts the count. In MEASURE an accepted edge restarts the count,
    // and it takes priority over the timeout check in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_strobe) begin
                        state <= MEASURE;
                        cnt   <= '0;
                    end
                end
                MEASURE: begin
                    if (emit) begin
                        cnt <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                TIMEOUT: begin
                    if (edge_strobe) begin
                        state   <= MEASURE;
                        cnt     <= '0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer. A new period may replace the held one only if
    // the held one is being consumed in the same cycle; otherwise it is lost
    // and overrun latches until reset, keeping period_data stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_data  <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (emit) begin
            if (!period_valid || period_ready) begin
                period_data  <= cnt_next;
                period_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
        end
    end

endmodule
